// File: rtl/sisc_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | sisc_pkg : shared encodings and defaults for the SISC memory path  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package sisc_pkg;

   localparam int AW_DEF = 16;
   localparam int DW_DEF = 32;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_ACCESS = 2'd1;
   localparam logic [1:0] ST_DONE   = 2'd2;

   typedef enum logic [1:0] {
      IDLE   = ST_IDLE,
      ACCESS = ST_ACCESS,
      DONE   = ST_DONE
   } arb_state_t;

   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_D  = 1'b1;

   // Single requester wins outright; a tie goes to whoever did not own the port last.
   function automatic logic pick_owner(input logic if_req, input logic d_req, input logic last_owner);
      logic owner;
      if (if_req && d_req) owner = ~last_owner;
      else if (d_req)      owner = OWN_D;
      else                 owner = OWN_IF;
      return owner;
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_port_arb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mem_port_arb : fetch/data arbiter for the shared SISC memory port  |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module mem_port_arb
   import sisc_pkg::*;
#(
   parameter int AW        = AW_DEF,
   parameter int DW        = DW_DEF,
   parameter int MEM_LAT   = 2,
   parameter bit DATA_PRIO = 1'b1
) (
   input  logic          clk,
   input  logic          rst_f,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_gnt,
   output logic          if_ack,
   output logic [DW-1:0] if_data,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_gnt,
   output logic          d_ack,
   output logic [DW-1:0] d_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   localparam logic [2:0] c_CNT_LOAD   = 3'(MEM_LAT - 1);
   localparam logic       c_LAST_RESET = DATA_PRIO ? OWN_IF : OWN_D;

   arb_state_t    r_state;
   arb_state_t    w_next;
   logic          w_grant;
   logic          w_sel;
   logic          r_owner;
   logic          r_last;
   logic          r_we;
   logic [2:0]    r_cnt;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_wdata;
   logic [DW-1:0] r_if_data;
   logic [DW-1:0] r_d_rdata;

   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      w_grant = 1'b0;
      w_sel   = pick_owner(if_req, d_req, r_last);
      case (r_state)
         IDLE: begin
            if (if_req || d_req) begin
               w_grant = 1'b1;
               w_next  = ACCESS;
            end
         end
         ACCESS:  if (r_cnt == 3'd0) w_next = DONE;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_f) begin
      if (!rst_f) begin
         r_owner   <= OWN_IF;
         r_last    <= c_LAST_RESET;
         r_we      <= 1'b0;
         r_cnt     <= 3'd0;
         r_addr    <= '0;
         r_wdata   <= '0;
         r_if_data <= '0;
         r_d_rdata <= '0;
      end else begin
         if (w_grant) begin
            r_owner <= w_sel;
            r_addr  <= (w_sel == OWN_D) ? d_addr : if_addr;
            r_we    <= (w_sel == OWN_D) && d_we;
            r_wdata <= (w_sel == OWN_D) ? d_wdata : '0;
            r_cnt   <= c_CNT_LOAD;
         end
         if (r_state == ACCESS) begin
            if (r_cnt == 3'd0) begin
               // Read data is only guaranteed on the final enabled cycle.
               if (r_owner == OWN_IF) r_if_data <= mem_rdata;
               else if (!r_we)        r_d_rdata <= mem_rdata;
            end else begin
               r_cnt <= r_cnt - 3'd1;
            end
         end
         if (r_state == DONE) r_last <= r_owner;
      end
   end

   assign busy      = (r_state != IDLE);
   assign mem_en    = (r_state == ACCESS);
   assign mem_we    = mem_en && r_we;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign if_gnt    = busy && (r_owner == OWN_IF);
   assign d_gnt     = busy && (r_owner == OWN_D);
   assign if_ack    = (r_state == DONE) && (r_owner == OWN_IF);
   assign d_ack     = (r_state == DONE) && (r_owner == OWN_D);
   assign if_data   = r_if_data;
   assign d_rdata   = r_d_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mem_port_arb : directed self-checking bench for mem_port_arb    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_mem_port_arb;

   localparam int AW    = 16;
   localparam int DW    = 32;
   localparam int LAT_A = 2;
   localparam int LAT_B = 7;

   logic clk   = 1'b0;
   logic rst_f = 1'b0;
   always #5 clk = ~clk;

   logic          a_if_req = 0, a_d_req = 0, a_d_we = 0;
   logic [AW-1:0] a_if_addr = '0, a_d_addr = '0;
   logic [DW-1:0] a_d_wdata = '0;
   logic          a_if_gnt, a_if_ack, a_d_gnt, a_d_ack, a_mem_en, a_mem_we, a_busy;
   logic [DW-1:0] a_if_data, a_d_rdata, a_mem_wdata, a_mem_rdata;
   logic [AW-1:0] a_mem_addr;

   logic          b_if_req = 0, b_d_req = 0;
   logic [AW-1:0] b_if_addr = '0, b_d_addr = '0;
   logic          b_if_gnt, b_if_ack, b_d_gnt, b_d_ack, b_mem_en, b_mem_we, b_busy;
   logic [DW-1:0] b_if_data, b_d_rdata, b_mem_wdata, b_mem_rdata;
   logic [AW-1:0] b_mem_addr;

   mem_port_arb #(.AW(AW), .DW(DW), .MEM_LAT(LAT_A), .DATA_PRIO(1'b1)) u_dut_a (
      .clk(clk), .rst_f(rst_f),
      .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt), .if_ack(a_if_ack), .if_data(a_if_data),
      .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
      .d_gnt(a_d_gnt), .d_ack(a_d_ack), .d_rdata(a_d_rdata),
      .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
      .mem_rdata(a_mem_rdata), .busy(a_busy)
   );

   mem_port_arb #(.AW(AW), .DW(DW), .MEM_LAT(LAT_B), .DATA_PRIO(1'b0)) u_dut_b (
      .clk(clk), .rst_f(rst_f),
      .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt), .if_ack(b_if_ack), .if_data(b_if_data),
      .d_req(b_d_req), .d_we(1'b0), .d_addr(b_d_addr), .d_wdata('0),
      .d_gnt(b_d_gnt), .d_ack(b_d_ack), .d_rdata(b_d_rdata),
      .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
      .mem_rdata(b_mem_rdata), .busy(b_busy)
   );

   // Memory models: read data is only valid on the last enabled cycle of an access.
   logic [DW-1:0] mem_a [0:255];
   logic [DW-1:0] mem_b [0:255];
   logic [2:0]    lat_a = '0;
   logic [2:0]    lat_b = '0;

   always @(posedge clk) begin
      if (a_mem_en) begin
         lat_a <= lat_a + 3'd1;
         if (a_mem_we) mem_a[a_mem_addr[7:0]] <= a_mem_wdata;
      end else begin
         lat_a <= '0;
      end
      if (b_mem_en) lat_b <= lat_b + 3'd1;
      else          lat_b <= '0;
   end

   assign a_mem_rdata = (a_mem_en && lat_a == 3'(LAT_A - 1)) ? mem_a[a_mem_addr[7:0]] : 32'hBAD0BAD0;
   assign b_mem_rdata = (b_mem_en && lat_b == 3'(LAT_B - 1)) ? mem_b[b_mem_addr[7:0]] : 32'hBAD0BAD0;

   int n_checks = 0;
   int n_fail   = 0;
   int a_if_acks = 0, a_d_acks = 0, excl_err = 0;

   always @(negedge clk) begin
      if (a_if_ack) a_if_acks++;
      if (a_d_ack)  a_d_acks++;
      if ((a_if_gnt && a_d_gnt) || (a_if_ack && a_d_ack) ||
          (b_if_gnt && b_d_gnt) || (b_if_ack && b_d_ack)) excl_err++;
   end

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0;
      int k;
      int b_first_if, b_first_d, busy_cnt;
      for (int i = 0; i < 256; i++) begin
         mem_a[i] = '0;
         mem_b[i] = '0;
      end
      mem_a[8'h10] = 32'h88110002;
      mem_b[8'h10] = 32'h0BADC0DE;
      mem_b[8'h20] = 32'hCAFEF00D;

      // Reset state
      #2;
      check_val("reset_ctrl", {a_busy, a_mem_en, a_mem_we, a_if_gnt, a_d_gnt, a_if_ack, a_d_ack}, 0);
      check_val("reset_data", {a_if_data, a_d_rdata}, 0);
      check_val("reset_addr", a_mem_addr, 0);
      repeat (2) @(posedge clk);
      #1 rst_f = 1'b1;

      // Fetch only
      a_if_req = 1; a_if_addr = 16'h0010;
      tick;
      check_val("fetch_acc1", {a_mem_en, a_mem_we, a_if_gnt, a_if_ack}, 4'b1010);
      check_val("fetch_addr", a_mem_addr, 16'h0010);
      a_if_addr = 16'h0080;
      tick;
      check_val("fetch_acc2", {a_mem_en, a_if_gnt, a_if_ack}, 3'b110);
      check_val("fetch_addr_held", a_mem_addr, 16'h0010);
      tick;
      check_val("fetch_done", {a_mem_en, a_if_gnt, a_if_ack, a_d_ack}, 4'b0110);
      check_val("fetch_data", a_if_data, 32'h88110002);
      a_if_req = 0;
      tick;
      check_val("fetch_idle", {a_busy, a_if_ack}, 2'b00);
      check_val("fetch_no_dack", a_d_acks, 0);

      // Store, then load back
      a_d_req = 1; a_d_we = 1; a_d_addr = 16'h0080; a_d_wdata = 32'hDEADBEEF;
      tick;
      check_val("store_acc1", {a_mem_en, a_mem_we, a_d_gnt}, 3'b111);
      check_val("store_wdata", a_mem_wdata, 32'hDEADBEEF);
      a_d_wdata = '0;
      tick;
      check_val("store_acc2", {a_mem_en, a_mem_we, a_mem_wdata}, {2'b11, 32'hDEADBEEF});
      tick;
      check_val("store_ack", {a_d_ack, a_mem_en}, 2'b10);
      check_val("store_rdata_held", a_d_rdata, 0);
      a_d_req = 0; a_d_we = 0;
      tick;
      a_d_req = 1;
      repeat (3) tick;
      check_val("load_ack", a_d_ack, 1);
      check_val("load_data", a_d_rdata, 32'hDEADBEEF);
      a_d_req = 0;
      tick;

      // Tie from reset: data first, then strict alternation
      rst_f = 0;
      #2 rst_f = 1;
      a_if_req = 1; a_if_addr = 16'h0010;
      a_d_req = 1; a_d_we = 0; a_d_addr = 16'h0080;
      k = 0;
      for (int t = 1; t <= 32; t++) begin
         tick;
         if (a_if_ack || a_d_ack) begin
            check_val($sformatf("tie_time%0d", k), t, 3 + 4 * k);
            check_val($sformatf("tie_owner%0d", k), a_d_ack, (k % 2 == 0) ? 1 : 0);
            k++;
         end
      end
      check_val("tie_grants", k, 8);
      check_val("tie_data", {a_if_data, a_d_rdata}, {32'h88110002, 32'hDEADBEEF});
      a_if_req = 0; a_d_req = 0;
      repeat (2) tick;

      // Early drop of fetch request after grant
      n0 = a_if_acks;
      a_if_req = 1;
      tick;
      a_if_req = 0;
      tick;
      tick;
      check_val("drop_ack", a_if_ack, 1);
      repeat (3) tick;
      check_val("drop_idle", a_busy, 0);
      check_val("drop_one_ack", a_if_acks, n0 + 1);

      // Asynchronous reset in the middle of a store
      a_d_req = 1; a_d_we = 1; a_d_addr = 16'h0040; a_d_wdata = 32'h12345678;
      tick;
      check_val("areset_pre", {a_mem_en, a_mem_we, a_d_gnt}, 3'b111);
      #2 rst_f = 0;
      #1;
      check_val("areset_drop", {a_mem_en, a_mem_we, a_d_gnt, a_busy, a_d_ack}, 0);
      a_d_we = 0; a_d_addr = 16'h0080;
      n0 = a_d_acks;
      #1 rst_f = 1;
      tick;
      check_val("areset_regrant", {a_d_gnt, a_mem_we, a_d_ack}, 3'b100);
      tick;
      tick;
      check_val("areset_ack", {a_d_ack, a_d_rdata}, {1'b1, 32'hDEADBEEF});
      a_d_req = 0;
      tick;
      check_val("areset_ack_count", a_d_acks, n0 + 1);
      check_val("areset_no_write", mem_a[8'h40], 0);

      // MEM_LAT=7 build, fetch preferred on the first tie
      rst_f = 0;
      #2 rst_f = 1;
      b_if_req = 1; b_if_addr = 16'h0010;
      b_d_req = 1;  b_d_addr = 16'h0020;
      b_first_if = -1; b_first_d = -1; busy_cnt = 0;
      for (int t = 1; t <= 17; t++) begin
         tick;
         if (t <= 9 && b_busy) busy_cnt++;
         if (b_if_ack && b_first_if < 0) b_first_if = t;
         if (b_d_ack && b_first_d < 0)  b_first_d = t;
      end
      b_if_req = 0; b_d_req = 0;
      check_val("lat7_if_ack_time", b_first_if, 8);
      check_val("lat7_busy_cycles", busy_cnt, 8);
      check_val("lat7_d_ack_time", b_first_d, 17);
      check_val("lat7_data", {b_if_data, b_d_rdata}, {32'h0BADC0DE, 32'hCAFEF00D});
      repeat (2) tick;

      check_val("exclusive", excl_err, 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
